// File: rtl/score_keeper_pkg.sv
`default_nettype none
// ============================================================================
// Module  : score_keeper_pkg
// Brief   : Widths, FSM states and helper tables shared by score_keeper.
// Revision: 1.0 - initial release
// ============================================================================
package score_keeper_pkg;

    localparam int CLEAR_LEN    = 3;
    localparam int SCORE_DIGITS = 4;
    localparam int SCORE_LEN    = 16;
    localparam int LINES_LEN    = 8;
    localparam int LEVEL_LEN    = 4;
    localparam int DROP_LEN     = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_LINES = 2'd2
    } state_t;

    // Base points per placement; anything above a tetris scores as a tetris.
    function automatic logic [3:0] clear_points(input logic [CLEAR_LEN-1:0] n);
        case (n)
            3'd0:    return 4'd0;
            3'd1:    return 4'd1;
            3'd2:    return 4'd3;
            3'd3:    return 4'd5;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [DROP_LEN-1:0] drop_for_level(input logic [LEVEL_LEN-1:0] lvl);
        return DROP_LEN'(48 - 5 * int'(lvl));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add_sat.sv
`default_nettype none
// ============================================================================
// Module  : bcd_add_sat
// Brief   : Four-digit BCD plus small binary addend, saturating at 9999.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_add_sat
    import score_keeper_pkg::*;
(
    input  logic [SCORE_LEN-1:0] i_a,
    input  logic [3:0]           i_b,
    output logic [SCORE_LEN-1:0] o_sum
);

    logic [4:0]           w_carry;
    logic [4:0]           w_dsum;
    logic [SCORE_LEN-1:0] w_raw;

    // The addend enters as the carry into digit 0; later digits only see 0/1.
    always_comb begin
        w_carry = {1'b0, i_b};
        w_dsum  = '0;
        w_raw   = '0;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            w_dsum = {1'b0, i_a[4*d +: 4]} + w_carry;
            if (w_dsum > 5'd9) begin
                w_raw[4*d +: 4] = 4'(w_dsum - 5'd10);
                w_carry         = 5'd1;
            end else begin
                w_raw[4*d +: 4] = w_dsum[3:0];
                w_carry         = 5'd0;
            end
        end
        o_sum = (w_carry != 5'd0) ? {SCORE_DIGITS{4'h9}} : w_raw;
    end

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module  : score_keeper
// Brief   : BCD score, line count, level and gravity period bookkeeping.
// Revision: 1.0 - initial release
// ============================================================================
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int LINES_PER_LEVEL = 10,
    parameter int LEVEL_MAX       = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_valid,
    input  logic [CLEAR_LEN-1:0] num_cleared,
    output logic                 busy,
    output logic                 done,
    output logic [SCORE_LEN-1:0] score_bcd,
    output logic [LINES_LEN-1:0] lines,
    output logic [LEVEL_LEN-1:0] level,
    output logic                 level_up,
    output logic [DROP_LEN-1:0]  drop_period,
    output logic                 overrun
);

    localparam logic [4:0]           c_lines_per_level = 5'(LINES_PER_LEVEL);
    localparam logic [LEVEL_LEN-1:0] c_level_max       = LEVEL_LEN'(LEVEL_MAX);
    localparam logic [CLEAR_LEN-1:0] c_n_max           = CLEAR_LEN'(4);

    state_t                r_state;
    logic [3:0]            r_base;
    logic [CLEAR_LEN-1:0]  r_n;
    logic [LEVEL_LEN-1:0]  r_iter;
    logic [SCORE_LEN-1:0]  r_score;
    logic [LINES_LEN-1:0]  r_lines;
    logic [LEVEL_LEN-1:0]  r_level;
    logic [3:0]            r_lvl_cnt;
    logic [DROP_LEN-1:0]   r_drop;
    logic                  r_done;
    logic                  r_level_up;
    logic                  r_overrun;

    logic [SCORE_LEN-1:0]  w_score_next;
    logic [LINES_LEN:0]    w_lines_sum;
    logic [LINES_LEN-1:0]  w_lines_next;
    logic [4:0]            w_cnt_sum;
    logic                  w_wrap;
    logic                  w_lvl_inc;
    logic [LEVEL_LEN-1:0]  w_level_next;

    bcd_add_sat u_bcd_add_sat (
        .i_a   (r_score),
        .i_b   (r_base),
        .o_sum (w_score_next)
    );

    always_comb begin
        w_lines_sum  = {1'b0, r_lines} + (LINES_LEN+1)'(r_n);
        w_lines_next = w_lines_sum[LINES_LEN] ? {LINES_LEN{1'b1}} : w_lines_sum[LINES_LEN-1:0];
        w_cnt_sum    = {1'b0, r_lvl_cnt} + 5'(r_n);
        w_wrap       = (w_cnt_sum >= c_lines_per_level);
        w_lvl_inc    = w_wrap && (r_level < c_level_max);
        w_level_next = w_lvl_inc ? r_level + 1'b1 : r_level;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_n        <= '0;
            r_iter     <= '0;
            r_score    <= '0;
            r_lines    <= '0;
            r_level    <= '0;
            r_lvl_cnt  <= '0;
            r_drop     <= drop_for_level('0);
            r_done     <= 1'b0;
            r_level_up <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_level_up <= 1'b0;
            if (clear_valid && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (clear_valid) begin
                        r_base  <= clear_points(num_cleared);
                        r_n     <= (num_cleared > c_n_max) ? c_n_max : num_cleared;
                        r_iter  <= r_level;
                        r_state <= (clear_points(num_cleared) != 4'd0) ? S_ADD : S_LINES;
                    end
                end
                // One base-sized add per cycle, level+1 times in total.
                S_ADD: begin
                    r_score <= w_score_next;
                    if (r_iter == '0) begin
                        r_state <= S_LINES;
                    end else begin
                        r_iter <= r_iter - 1'b1;
                    end
                end
                S_LINES: begin
                    r_lines    <= w_lines_next;
                    r_lvl_cnt  <= w_wrap ? 4'(w_cnt_sum - c_lines_per_level) : w_cnt_sum[3:0];
                    r_level    <= w_level_next;
                    r_drop     <= drop_for_level(w_level_next);
                    r_done     <= 1'b1;
                    r_level_up <= w_lvl_inc;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign score_bcd   = r_score;
    assign lines       = r_lines;
    assign level       = r_level;
    assign level_up    = r_level_up;
    assign drop_period = r_drop;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire
